// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler sharing one multi-cycle FP adder among N_REQ requesters
module fp_add_sched #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_areset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  add_start,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    input  logic                  add_done,
    input  logic [31:0]           add_result,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt_id;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;
    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [31:0]       gnt_a;
    logic [31:0]       gnt_b;

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign rsp_id     = gnt_id;

    // Scan from ptr upward; iterating in reverse lets the closest index to ptr win.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                gnt_a = req_a[32*k +: 32];
                gnt_b = req_b[32*k +: 32];
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (gnt_any) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (add_done || wd_expired) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
        add_start = (state == S_ISSUE);
        rsp_valid = (state == S_RESP);
    end

    // Operands are captured once at grant and never re-sampled while the adder works.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ptr      <= '0;
            gnt_id   <= '0;
            add_a    <= '0;
            add_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        gnt_id <= gnt_idx;
                        add_a  <= gnt_a;
                        add_b  <= gnt_b;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (add_done) begin
                        rsp_data <= add_result;
                        rsp_err  <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_data <= QNAN;
                        rsp_err  <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - scoreboard bench for fp_add_sched with a behavioural adder model
module tb_fp_add_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 8;

    logic              s00_axi_aclk = 1'b0;
    logic              s00_axi_areset;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic              add_start;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_done;
    logic [31:0]       add_result;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              rsp_ready;

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    fp_add_sched #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .s00_axi_aclk   (s00_axi_aclk),
        .s00_axi_areset (s00_axi_areset),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ready      (req_ready),
        .add_start      (add_start),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_done       (add_done),
        .add_result     (add_result),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_ready      (rsp_ready)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] op_a [N][16];
    logic [31:0] op_b [N][16];
    int          head [N];
    int          tail [N];
    bit          gflag [N];
    logic [34:0] sb [$];
    int          glog [$];

    int          lat = 3;
    bit          stray_req = 0;
    int          grant_cyc, start_cyc, rise_cyc, n_starts;
    logic [31:0] pend_a, pend_b;

    always @(posedge s00_axi_aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a + b;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = (tail[i] > head[i]);
            req_a[32*i +: 32]  = (tail[i] > head[i]) ? op_a[i][head[i]] : 32'h0;
            req_b[32*i +: 32]  = (tail[i] > head[i]) ? op_b[i][head[i]] : 32'h0;
        end
    endtask

    task automatic push_op(input int lane, input logic [31:0] a, input logic [31:0] b,
                           input bit exp_rsp, input bit to);
        op_a[lane][tail[lane]] = a;
        op_b[lane][tail[lane]] = b;
        tail[lane]++;
        if (exp_rsp) sb.push_back({to, IDW'(lane), to ? 32'h7FC00000 : fadd(a, b)});
    endtask

    function automatic bit lanes_empty();
        for (int i = 0; i < N; i++) if (tail[i] > head[i]) return 0;
        return 1;
    endfunction

    task automatic step();
        @(posedge s00_axi_aclk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        bit done;
        done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            done = (sb.size() == 0) && (rsp_valid == 1'b0) && lanes_empty();
        end
        chk({name, "_drain"}, 64'(done), 64'd1);
    endtask

    // Requesters: retire the granted operand pair after the grant edge, then re-present.
    initial begin
        forever begin
            @(posedge s00_axi_aclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (gflag[i]) begin
                    head[i]++;
                    gflag[i] = 0;
                end
            end
            refresh();
        end
    end

    // Adder model: pulses add_done lat cycles after add_start; lat==0 never answers.
    initial begin
        int          cnt;
        bit          busy;
        logic [31:0] la, lb;
        cnt = 0; busy = 0; la = 0; lb = 0;
        add_done = 0;
        add_result = 0;
        forever begin
            @(negedge s00_axi_aclk);
            add_done = 0;
            if (stray_req) begin
                add_done = 1;
                add_result = 32'hDEADBEEF;
                stray_req = 0;
            end else if (add_start) begin
                if (lat > 0) begin
                    busy = 1; cnt = lat; la = add_a; lb = add_b;
                end
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    add_done = 1;
                    add_result = fadd(la, lb);
                end
            end
        end
    end

    initial begin
        bit          prev_rv;
        int          gid;
        logic [34:0] e;
        prev_rv = 0;
        gid = 0;
        forever begin
            @(negedge s00_axi_aclk);
            if (s00_axi_areset) begin
                prev_rv = 0;
            end else begin
                if (req_ready != '0) begin
                    chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
                    for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
                    gflag[gid] = 1;
                    pend_a = op_a[gid][head[gid]];
                    pend_b = op_b[gid][head[gid]];
                    glog.push_back(gid);
                    grant_cyc = cyc;
                end
                if (add_start) begin
                    start_cyc = cyc;
                    n_starts++;
                    chk("add_a", 64'(add_a), 64'(pend_a));
                    chk("add_b", 64'(add_b), 64'(pend_b));
                end
                if (rsp_valid && !prev_rv) rise_cyc = cyc;
                if (rsp_valid && rsp_ready) begin
                    chk("rsp_expected", 64'(sb.size() > 0), 64'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("rsp_id",   64'(rsp_id),   64'(e[33:32]));
                        chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                        chk("rsp_err",  64'(rsp_err),  64'(e[34]));
                    end
                end
                prev_rv = rsp_valid;
            end
        end
    end

    initial begin
        logic [31:0] a1, b1;
        int          s0;
        s00_axi_areset = 1;
        rsp_ready = 1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        n_starts = 0;
        repeat (3) @(posedge s00_axi_aclk);
        #2;
        s00_axi_areset = 0;

        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_add_start", 64'(add_start), 64'd0);
        chk("rst_add_a",     64'(add_a),     64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);

        // single request, L=6
        lat = 6;
        push_op(2, 32'h3F800000, 32'h40000000, 1, 0);
        refresh();
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'b0100);
        wait_drain("t1", 100);
        chk("t1_start_lat", 64'(start_cyc - grant_cyc), 64'd1);
        chk("t1_rsp_lat",   64'(rise_cyc - grant_cyc),  64'd8);

        s00_axi_areset = 1;
        step();
        s00_axi_areset = 0;

        // all requesters valid, L=3
        lat = 3;
        glog.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_op(i, $urandom, $urandom, 1, 0);
        refresh();
        wait_drain("t2", 400);
        chk("t2_grants", 64'(glog.size()), 64'd8);
        for (int k = 0; k < glog.size() && k < 8; k++) chk("t2_order", 64'(glog[k]), 64'(k % N));

        // back-pressure with stray add_done
        lat = 2;
        rsp_ready = 0;
        a1 = $urandom;
        b1 = $urandom;
        push_op(1, a1, b1, 1, 0);
        push_op(3, $urandom, $urandom, 1, 0);
        refresh();
        for (int k = 0; k < 50 && !rsp_valid; k++) step();
        chk("t3_rsp_seen", 64'(rsp_valid), 64'd1);
        for (int j = 0; j < 10; j++) begin
            chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t3_hold_id",    64'(rsp_id),    64'd1);
            chk("t3_hold_data",  64'(rsp_data),  64'(fadd(a1, b1)));
            chk("t3_no_ready",   64'(req_ready), 64'd0);
            if (j == 3) stray_req = 1;
            step();
        end
        rsp_ready = 1;
        wait_drain("t3", 100);

        // timeout then a normal operation
        lat = 0;
        push_op(0, $urandom, $urandom, 1, 1);
        refresh();
        wait_drain("t4", 100);
        chk("t4_to_lat", 64'(rise_cyc - start_cyc), 64'(TO + 1));
        lat = 2;
        push_op(2, $urandom, $urandom, 1, 0);
        refresh();
        wait_drain("t4b", 100);
        chk("t4b_lat", 64'(rise_cyc - start_cyc), 64'd3);

        // completion one cycle before and exactly at watchdog expiry
        lat = TO - 1;
        push_op(3, $urandom, $urandom, 1, 0);
        refresh();
        wait_drain("t6a", 100);
        chk("t6a_lat", 64'(rise_cyc - start_cyc), 64'(TO));
        lat = TO;
        push_op(2, $urandom, $urandom, 1, 0);
        refresh();
        wait_drain("t6b", 100);
        chk("t6b_lat", 64'(rise_cyc - start_cyc), 64'(TO + 1));

        // reset in WAIT, late add_done, then power-up style arbitration
        lat = 5;
        s0 = n_starts;
        push_op(3, $urandom, $urandom, 0, 0);
        refresh();
        for (int k = 0; k < 20 && n_starts == s0; k++) step();
        chk("t5_started", 64'(n_starts - s0), 64'd1);
        step();
        step();
        s00_axi_areset = 1;
        step();
        s00_axi_areset = 0;
        for (int j = 0; j < 4; j++) begin
            chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("t5_add_start", 64'(add_start), 64'd0);
            chk("t5_add_a",     64'(add_a),     64'd0);
            chk("t5_add_b",     64'(add_b),     64'd0);
            chk("t5_rsp_data",  64'(rsp_data),  64'd0);
            chk("t5_rsp_err",   64'(rsp_err),   64'd0);
            chk("t5_rsp_id",    64'(rsp_id),    64'd0);
            step();
        end
        glog.delete();
        lat = 2;
        push_op(1, $urandom, $urandom, 1, 0);
        push_op(3, $urandom, $urandom, 1, 0);
        refresh();
        wait_drain("t5", 100);
        chk("t5_grants", 64'(glog.size()), 64'd2);
        if (glog.size() >= 2) begin
            chk("t5_first",  64'(glog[0]), 64'd1);
            chk("t5_second", 64'(glog[1]), 64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
